// File: rtl/wb_queue_if.sv
// Bundle of the writeback request, RF drain and forwarding signals for wb_queue.
// The slave modport is the queue's view. The master modport is the view of the producer and the RF side.
interface wb_queue_if #(parameter int AW = 2);
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_rd;
  logic [31:0]   in_data;
  logic          drain_en;
  logic          RFWr;
  logic [4:0]    A3;
  logic [31:0]   WD;
  logic [4:0]    A1;
  logic [4:0]    A2;
  logic          fwd1_hit;
  logic [31:0]   fwd1_data;
  logic          fwd2_hit;
  logic [31:0]   fwd2_data;
  logic [AW:0]   count;
  logic          empty;
  logic          full;

  modport slave (
    input  in_valid, in_rd, in_data, drain_en, A1, A2,
    output in_ready, RFWr, A3, WD, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
           count, empty, full
  );

  modport master (
    output in_valid, in_rd, in_data, drain_en, A1, A2,
    input  in_ready, RFWr, A3, WD, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
           count, empty, full
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue in front of the register-file write port. It drains one entry per cycle in strict FIFO order.
// It also forwards the youngest queued value to the two decode read addresses.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  wb_queue_if.slave   q
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [4:0]    rdMem   [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   cnt;

  logic isEmpty;
  logic isFull;
  logic accept;
  logic push;
  logic pop;

  assign isEmpty = (cnt == '0);
  assign isFull  = (cnt == CNT_FULL);
  assign accept  = q.in_valid & ~isFull;
  assign push    = accept & (q.in_rd != 5'd0);
  assign pop     = q.drain_en & ~isEmpty;

  assign q.in_ready = ~isFull;
  assign q.count    = cnt;
  assign q.empty    = isEmpty;
  assign q.full     = isFull;
  assign q.RFWr     = pop;
  assign q.A3       = isEmpty ? 5'd0  : rdMem[head];
  assign q.WD       = isEmpty ? 32'd0 : dataMem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      if (push && !pop)      cnt <= cnt + CNT_ONE;
      else if (pop && !push) cnt <= cnt - CNT_ONE;
    end
  end

  // Entry storage is not cleared on reset; only the occupancy state matters.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      rdMem[tail]   <= q.in_rd;
      dataMem[tail] <= q.in_data;
    end
  end

  // Scan from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [AW-1:0] idx;
    logic          hit1;
    logic          hit2;
    logic [31:0]   dat1;
    logic [31:0]   dat2;
    idx  = head;
    hit1 = 1'b0;
    hit2 = 1'b0;
    dat1 = 32'd0;
    dat2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((AW+1)'(i) < cnt) begin
        if (q.A1 != 5'd0 && rdMem[idx] == q.A1) begin
          hit1 = 1'b1;
          dat1 = dataMem[idx];
        end
        if (q.A2 != 5'd0 && rdMem[idx] == q.A2) begin
          hit2 = 1'b1;
          dat2 = dataMem[idx];
        end
      end
    end
    q.fwd1_hit  = hit1;
    q.fwd1_data = dat1;
    q.fwd2_hit  = hit2;
    q.fwd2_data = dat2;
  end

endmodule

// File: tb/tb_wb_queue.sv
// Drives directed scenarios and random writeback and drain traffic into wb_queue.
// Every cycle it compares the DUT outputs against a queue-based reference model.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [36:0] mq[$];

  wb_queue_if #(.AW(AW)) bus ();

  wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void fwdLookup(input logic [4:0] a, output logic hit, output logic [31:0] dat);
    hit = 1'b0;
    dat = 32'd0;
    if (a != 5'd0) begin
      for (int j = mq.size() - 1; j >= 0; j--) begin
        if (mq[j][36:32] == a) begin
          hit = 1'b1;
          dat = mq[j][31:0];
          break;
        end
      end
    end
  endfunction

  // One cycle: drive at negedge, check the settled outputs, then advance the model across the posedge.
  task automatic applyStimulus(input logic r, input logic v, input logic [4:0] rd, input logic [31:0] d,
                               input logic dr, input logic [4:0] a1, input logic [4:0] a2);
    logic        expFull, expReady, expPush, expPop, h1, h2;
    logic [31:0] d1, d2;
    rst          = r;
    bus.in_valid = v;
    bus.in_rd    = rd;
    bus.in_data  = d;
    bus.drain_en = dr;
    bus.A1       = a1;
    bus.A2       = a2;
    #2;
    expFull  = (mq.size() == DEPTH);
    expReady = !expFull;
    expPush  = v && expReady && (rd != 5'd0);
    expPop   = dr && (mq.size() != 0);
    fwdLookup(a1, h1, d1);
    fwdLookup(a2, h2, d2);
    checkOutput("in_ready",  32'(bus.in_ready),  32'(expReady));
    checkOutput("full",      32'(bus.full),      32'(expFull));
    checkOutput("empty",     32'(bus.empty),     32'(mq.size() == 0));
    checkOutput("count",     32'(bus.count),     32'(mq.size()));
    checkOutput("RFWr",      32'(bus.RFWr),      32'(expPop));
    checkOutput("A3",        32'(bus.A3),        mq.size() != 0 ? 32'(mq[0][36:32]) : 32'd0);
    checkOutput("WD",        bus.WD,             mq.size() != 0 ? mq[0][31:0] : 32'd0);
    checkOutput("fwd1_hit",  32'(bus.fwd1_hit),  32'(h1));
    checkOutput("fwd1_data", bus.fwd1_data,      d1);
    checkOutput("fwd2_hit",  32'(bus.fwd2_hit),  32'(h2));
    checkOutput("fwd2_data", bus.fwd2_data,      d2);
    @(posedge clk);
    if (r) mq.delete();
    else begin
      if (expPop)  void'(mq.pop_front());
      if (expPush) mq.push_back({rd, d});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic dr, input logic [4:0] a1, input logic [4:0] a2);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, dr, a1, a2);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_rd    = 5'd0;
    bus.in_data  = 32'd0;
    bus.drain_en = 1'b0;
    bus.A1       = 5'd0;
    bus.A2       = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    idle(1, 1'b0, 5'd3, 5'd0);

    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd0);
    idle(2, 1'b1, 5'd5, 5'd0);

    for (int k = 1; k <= 5; k++)
      applyStimulus(1'b0, 1'b1, 5'(k), 32'(k * 32'h11), 1'b0, 5'(k), 5'd2);
    idle(5, 1'b1, 5'd4, 5'd1);

    applyStimulus(1'b0, 1'b1, 5'd7, 32'h100, 1'b0, 5'd7, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h200, 1'b0, 5'd7, 5'd0);
    idle(1, 1'b0, 5'd7, 5'd0);
    idle(3, 1'b1, 5'd7, 5'd0);

    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
    idle(2, 1'b1, 5'd0, 5'd0);

    for (int k = 1; k <= 3; k++)
      applyStimulus(1'b0, 1'b1, 5'(k + 8), 32'(k), 1'b0, 5'd9, 5'd10);
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b0, 1'b1, 5'(12 + k), 32'hA000 + 32'(k), 1'b1, 5'(12 + k), 5'(11 + k));
    applyStimulus(1'b1, 1'b1, 5'd20, 32'h5, 1'b1, 5'd20, 5'd0);
    idle(1, 1'b1, 5'd20, 5'd0);

    for (int k = 0; k < 600; k++)
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                    $urandom, $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-side companion to the CPU register file: buffers register writeback requests from the execute/memory stages and drains them into the RF single write port, one per cycle.
- Provides a forwarding lookup on two read addresses so decode sees values still queued and not yet written to the RF.
- Sits between the writeback mux and the RF write port (RFWr/A3/WD).

Parameters:
DEPTH, 4, number of queue entries; must be a power of two, minimum 2.
AW, 2, pointer width; equals log2(DEPTH).

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  writeback request valid
in_ready  out  1  queue can accept a request this cycle
in_rd  in  5  destination register index
in_data  in  32  writeback value
drain_en  in  1  RF write port available this cycle
RFWr  out  1  RF write enable
A3  out  5  RF write address (head entry rd)
WD  out  32  RF write data (head entry data)
A1  in  5  forwarding lookup address 1
A2  in  5  forwarding lookup address 2
fwd1_hit  out  1  A1 matches a queued entry
fwd1_data  out  32  data of youngest matching entry for A1, else 0
fwd2_hit  out  1  A2 matches a queued entry
fwd2_data  out  32  data of youngest matching entry for A2, else 0
count  out  AW+1  number of occupied entries
empty  out  1  count == 0
full  out  1  count == DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries {rd[4:0], data[31:0]}, head pointer, tail pointer, count register (AW+1 bits). Pointers wrap modulo DEPTH.
- Reset (posedge clk with rst=1): head=0, tail=0, count=0. Entry contents need not be cleared. After reset: in_ready=1, RFWr=0, empty=1, full=0, fwd*_hit=0, fwd*_data=0. Reset overrides any push or pop in the same cycle. Reset mid-drain discards all queued writes.
- in_ready = ~full. No pass-through when full, even if a pop occurs the same cycle.
- Accept = in_valid & in_ready.
- Push = accept & (in_rd != 0). An accepted request to x0 completes the handshake but is discarded: no entry, no count change.
- Pop = drain_en & ~empty. RFWr = pop; A3/WD = head entry fields, combinational from head. A3=0 and WD=0 when empty.
- Latency: a pushed entry appears at the RF port no earlier than the cycle after the push. No same-cycle bypass from in_* to RFWr/A3/WD.
- Simultaneous push and pop: both take effect, count unchanged, head and tail both advance.
- Order: strict FIFO. Multiple entries for the same rd drain in arrival order, so the last write wins in the RF.
- Forwarding: combinational search over occupied entries only; the incoming in_* request is not searched.
  - Youngest match (closest to tail) wins.
  - A1/A2 == 0 never hits.
  - The head entry being popped this cycle still counts as a hit.
  - No hit gives data 0.
- count, empty and full are registered-state derived and glitch-free relative to the inputs.
- drain_en=0 holds the queue. Pushes continue until full.

Test Plan:
- Reset then idle: assert rst 2 cycles -> count=0, empty=1, in_ready=1, RFWr=0, A3=0, fwd1_hit=0.
- Single write: push rd=5, data=0xDEADBEEF, drain_en=1 -> next cycle RFWr=1, A3=5, WD=0xDEADBEEF; cycle after: empty=1.
- Fill and stall: drain_en=0, push rd=1..4 with data 0x11..0x44 -> full=1, in_ready=0. A 5th in_valid is not accepted. Then drain_en=1 -> A3 sequence 1,2,3,4 over 4 cycles.
- Forwarding priority: queue rd=7/0x100 then rd=7/0x200, drain_en=0, A1=7, A2=0 -> fwd1_hit=1, fwd1_data=0x200, fwd2_hit=0. After both drain -> fwd1_hit=0.
- x0 discard: push rd=0, data=0xFFFFFFFF -> handshake completes, count stays 0, RFWr never asserts.
- Simultaneous push/pop with wrap: hold count=3, push and pop every cycle for 8 cycles -> count stays 3, RF sees entries in push order across pointer wrap. Assert rst mid-stream -> next cycle count=0, RFWr=0.
